// File: rtl/usadd_pkg.sv
// Shared constants, state encoding and width helpers for the N-input unary scaled adder.
package usadd_pkg;

    localparam logic MODE_SCALED = 1'b0;
    localparam logic MODE_SAT    = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/usadd_popcnt.sv
// Combinational masked popcount over NUM_IN (<= 32) channels.
module usadd_popcnt
    import usadd_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int CW     = clog2(NUM_IN + 1)
) (
    input  logic [NUM_IN-1:0] iA,
    input  logic [NUM_IN-1:0] iMask,
    output logic [CW-1:0]     oCnt
);

    logic [31:0] masked;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            if (gi < NUM_IN) begin : g_ch
                assign masked[gi] = iA[gi] & iMask[gi];
            end else begin : g_pad
                assign masked[gi] = 1'b0;
            end
        end
    endgenerate

    assign oCnt = CW'(popcount(masked));

endmodule

// File: rtl/usadd_multi.sv
// N-input unary adder: per-cycle popcount feeds a residual accumulator that emits one
// output bit per accepted input cycle, as a channel mean (scaled) or a saturating sum.
module usadd_multi
    import usadd_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int WIN_LEN = 256,
    parameter int ACC_MAX = 7
) (
    input  logic                           iClk,
    input  logic                           iRstN,
    input  logic                           iClr,
    input  logic                           iStart,
    input  logic [NUM_IN-1:0]              iChMask,
    input  logic                           iMode,
    input  logic                           iEn,
    input  logic [NUM_IN-1:0]              iA,
    output logic                           oBit,
    output logic                           oValid,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [clog2(WIN_LEN+1)-1:0]    oOnesCnt
);

    localparam int CW     = clog2(NUM_IN + 1);
    localparam int SAT_W  = clog2(ACC_MAX + NUM_IN + 1);
    localparam int ACC_W  = (CW + 1 > SAT_W) ? CW + 1 : SAT_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam int OW     = clog2(WIN_LEN + 1);

    state_t            state_q, state_d;
    logic [NUM_IN-1:0] mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [CW-1:0]     den_q, den_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OW-1:0]     win_q, win_d;
    logic [OW-1:0]     ones_q, ones_d;
    logic              bit_q, bit_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     den_start;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_m1;
    logic              out_bit;

    usadd_popcnt #(.NUM_IN(NUM_IN), .CW(CW)) u_cnt (
        .iA    (iA),
        .iMask (mask_q),
        .oCnt  (cnt)
    );

    // Same counter on an all-ones input gives the number of enabled channels.
    usadd_popcnt #(.NUM_IN(NUM_IN), .CW(CW)) u_den (
        .iA    ({NUM_IN{1'b1}}),
        .iMask (iChMask),
        .oCnt  (den_start)
    );

    assign sum    = SUM_W'(acc_q) + SUM_W'(cnt);
    assign sum_m1 = sum - SUM_W'(1);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        den_d   = den_q;
        acc_d   = acc_q;
        win_d   = win_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        out_bit = 1'b0;

        if (iClr) begin
            state_d = IDLE;
            acc_d   = '0;
            win_d   = '0;
            ones_d  = '0;
        end else if (iStart) begin
            state_d = RUN;
            mask_d  = iChMask;
            mode_d  = iMode;
            den_d   = den_start;
            acc_d   = '0;
            win_d   = '0;
            ones_d  = '0;
        end else if (state_q == RUN && iEn) begin
            if (mode_q == MODE_SAT) begin
                // Residual above ACC_MAX is discarded rather than wrapped.
                if (sum != '0) begin
                    out_bit = 1'b1;
                    acc_d   = (sum_m1 > SUM_W'(ACC_MAX)) ? ACC_W'(ACC_MAX) : ACC_W'(sum_m1);
                end
            end else if (den_q != '0 && sum >= SUM_W'(den_q)) begin
                out_bit = 1'b1;
                acc_d   = ACC_W'(sum - SUM_W'(den_q));
            end else begin
                acc_d = ACC_W'(sum);
            end

            bit_d   = out_bit;
            valid_d = 1'b1;
            ones_d  = ones_q + OW'(out_bit);
            if (win_q == OW'(WIN_LEN - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                win_d = win_q + OW'(1);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            den_q   <= '0;
            acc_q   <= '0;
            win_q   <= '0;
            ones_q  <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            den_q   <= den_d;
            acc_q   <= acc_d;
            win_q   <= win_d;
            ones_q  <= ones_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign oBit     = bit_q;
    assign oValid   = valid_q;
    assign oBusy    = (state_q == RUN);
    assign oDone    = done_q;
    assign oOnesCnt = ones_q;

endmodule
